// File: rtl/fft_pkg.sv
// Shared constants, types and latency helpers for the radix-2 SDF FFT sequencer.
package fft_pkg;

  localparam int unsigned FFT_N_POINTS  = 64;
  localparam int unsigned FFT_LOG2N     = $clog2(FFT_N_POINTS);
  localparam int unsigned FFT_STAGE_LAT = 1;

  typedef enum logic {IDLE, RUN} ctrl_state_t;

  // Cycles from an input sop until stage s sees the first sample of that frame.
  function automatic int unsigned stage_off(input int unsigned s,
                                            input int unsigned n   = FFT_N_POINTS,
                                            input int unsigned lat = FFT_STAGE_LAT);
    int unsigned acc;
    acc = 0;
    for (int unsigned k = 0; k < s; k++) acc += (n >> (k + 1)) + lat;
    return acc;
  endfunction

  function automatic int unsigned total_lat(input int unsigned n   = FFT_N_POINTS,
                                            input int unsigned lat = FFT_STAGE_LAT);
    return n - 1 + $clog2(n) * lat;
  endfunction

  function automatic int unsigned bitrev(input int unsigned x,
                                         input int unsigned width = FFT_LOG2N);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < width; i++) r[width-1-i] = x[i];
    return r;
  endfunction

endpackage

// File: rtl/fft_stage_phase.sv
// Per-stage phase counter: restarts at 0 on its token tap and drives the commutator
// select and the stage-active window.
module fft_stage_phase
  import fft_pkg::*;
#(
  parameter int unsigned N_POINTS  = FFT_N_POINTS,
  parameter int unsigned STAGE_LAT = FFT_STAGE_LAT,
  parameter int unsigned STAGE     = 0,
  parameter int unsigned OFFSET    = 0,
  localparam int unsigned LOG2N    = $clog2(N_POINTS)
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_tap,
  output logic o_sel,
  output logic o_active
);

  localparam int unsigned CW = LOG2N + 1;
  localparam logic [CW-1:0] LAST    = CW'(N_POINTS - 1);
  localparam logic [CW-1:0] SPAN_M1 = CW'(N_POINTS + (N_POINTS >> (STAGE + 1)) - 1);

  // The tap position is chosen by the parent; reject an inconsistent instance early.
  if (STAGE >= LOG2N || OFFSET != stage_off(STAGE, N_POINTS, STAGE_LAT)) begin : g_bad_cfg
    $error("fft_stage_phase: inconsistent STAGE/OFFSET");
  end

  logic [CW-1:0] r_phase;
  logic [CW-1:0] r_rem;
  logic [CW-1:0] w_phase;

  assign w_phase  = i_tap ? '0 : r_phase;
  assign o_active = i_tap | (r_rem != '0);
  assign o_sel    = o_active & w_phase[LOG2N-1-STAGE];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_phase <= '0;
      r_rem   <= '0;
    end else begin
      r_phase <= (w_phase == LAST) ? '0 : w_phase + CW'(1);
      if (i_tap) begin
        r_rem <= SPAN_M1;
      end else if (r_rem != '0) begin
        r_rem <= r_rem - CW'(1);
      end
    end
  end

endmodule

// File: rtl/fft_sdf_ctrl.sv
// Frame sequencer for a radix-2 SDF FFT pipeline: input framing FSM, token delay line,
// per-stage commutator selects and output markers. FFT_SDF_CTRL_BITREV_EN selects
// bit-reversed out_index instead of natural order.
module fft_sdf_ctrl
  import fft_pkg::*;
#(
  parameter int unsigned N_POINTS  = FFT_N_POINTS,
  parameter int unsigned STAGE_LAT = FFT_STAGE_LAT,
  localparam int unsigned LOG2N    = $clog2(N_POINTS)
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_in_valid,
  input  logic             i_in_sop,
  output logic [LOG2N-1:0] o_stage_sel,
  output logic [LOG2N-1:0] o_stage_active,
  output logic             o_out_valid,
  output logic             o_out_sop,
  output logic [LOG2N-1:0] o_out_index,
  output logic             o_busy,
  output logic             o_err_gap,
  output logic             o_err_sop
);

  localparam int unsigned TOTAL_LAT = total_lat(N_POINTS, STAGE_LAT);
  localparam int unsigned CW        = LOG2N + 1;
  localparam logic [CW-1:0] LAST    = CW'(N_POINTS - 1);

  ctrl_state_t r_state, w_state_nxt;
  logic [CW-1:0] r_in_cnt, w_in_cnt_nxt;
  logic w_tok_in, w_abort, w_err_gap, w_err_sop;

  logic [TOTAL_LAT:1] r_tok;
  logic [TOTAL_LAT:0] w_tok, w_tok_keep;

  logic [CW-1:0] r_out_rem, r_out_idx, w_idx;
  logic w_out_valid;

  assign w_tok_in = i_in_valid & i_in_sop & ~i_reset;

  always_comb begin
    w_state_nxt  = r_state;
    w_in_cnt_nxt = r_in_cnt;
    w_abort      = 1'b0;
    w_err_gap    = 1'b0;
    w_err_sop    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_in_valid && i_in_sop) begin
          w_state_nxt  = RUN;
          w_in_cnt_nxt = CW'(1);
        end
      end
      RUN: begin
        if (!i_in_valid) begin
          w_err_gap    = 1'b1;
          w_abort      = 1'b1;
          w_state_nxt  = IDLE;
          w_in_cnt_nxt = '0;
        end else if (i_in_sop) begin
          w_err_sop    = 1'b1;
          w_abort      = 1'b1;
          w_in_cnt_nxt = CW'(1);
        end else if (r_in_cnt == LAST) begin
          // A sop on the following sample is picked up from IDLE with no bubble.
          w_state_nxt  = IDLE;
          w_in_cnt_nxt = '0;
        end else begin
          w_in_cnt_nxt = r_in_cnt + CW'(1);
        end
      end
      default: begin
        w_state_nxt  = IDLE;
        w_in_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= IDLE;
      r_in_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_in_cnt <= w_in_cnt_nxt;
    end
  end

  // w_tok[k] marks a sop accepted k cycles ago.
  assign w_tok = {r_tok, w_tok_in};

  // The frame being aborted is the only token younger than N_POINTS cycles.
  always_comb begin
    w_tok_keep = w_tok;
    if (w_abort) begin
      for (int j = 1; j < int'(N_POINTS); j++) w_tok_keep[j] = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_tok <= '0;
    end else begin
      r_tok <= w_tok_keep[TOTAL_LAT-1:0];
    end
  end

  for (genvar s = 0; s < LOG2N; s++) begin : g_stage
    localparam int unsigned OFF = stage_off(s, N_POINTS, STAGE_LAT);
    fft_stage_phase #(
      .N_POINTS  (N_POINTS),
      .STAGE_LAT (STAGE_LAT),
      .STAGE     (s),
      .OFFSET    (OFF)
    ) u_phase (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_tap    (w_tok[OFF]),
      .o_sel    (o_stage_sel[s]),
      .o_active (o_stage_active[s])
    );
  end

  assign o_out_sop   = w_tok[TOTAL_LAT];
  assign w_out_valid = o_out_sop | (r_out_rem != '0);
  assign w_idx       = o_out_sop ? '0 : r_out_idx;
  assign o_out_valid = w_out_valid;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_out_rem <= '0;
      r_out_idx <= '0;
    end else begin
      if (o_out_sop) begin
        r_out_rem <= LAST;
      end else if (r_out_rem != '0) begin
        r_out_rem <= r_out_rem - CW'(1);
      end
      r_out_idx <= (w_out_valid && w_idx != LAST) ? w_idx + CW'(1) : '0;
    end
  end

`ifdef FFT_SDF_CTRL_BITREV_EN
  assign o_out_index = LOG2N'(bitrev(32'(w_idx), LOG2N));
`else
  assign o_out_index = w_idx[LOG2N-1:0];
`endif

  assign o_busy    = (r_state == RUN) | (|w_tok) | w_out_valid;
  assign o_err_gap = w_err_gap;
  assign o_err_sop = w_err_sop;

endmodule

// File: tb/tb_fft_sdf_ctrl.sv
// Self-checking bench for fft_sdf_ctrl (N_POINTS=16, STAGE_LAT=1): frame-list reference
// model checked every cycle, plus directed scenarios with literal expectations.
module tb_fft_sdf_ctrl;

  localparam int N    = 16;
  localparam int LG   = 4;
  localparam int T    = 19;
  localparam int BIG  = 1 << 30;
  localparam int HMAX = 4096;
`ifdef FFT_SDF_CTRL_BITREV_EN
  localparam int IDX1 = 8;
`else
  localparam int IDX1 = 1;
`endif

  logic clk = 1'b0;
  logic rst, vin, sin;
  logic [LG-1:0] sel, act, oidx;
  logic ov, osop, busy, egap, esop;

  fft_sdf_ctrl #(.N_POINTS(N), .STAGE_LAT(1)) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_in_valid     (vin),
    .i_in_sop       (sin),
    .o_stage_sel    (sel),
    .o_stage_active (act),
    .o_out_valid    (ov),
    .o_out_sop      (osop),
    .o_out_index    (oidx),
    .o_busy         (busy),
    .o_err_gap      (egap),
    .o_err_sop      (esop)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int off[LG] = '{0, 9, 14, 17};

  int sop_q[$];
  int kill_q[$];
  bit m_run = 1'b0;
  int m_start = 0;

  int last_acc = 0, last_osop = 0, n_ov = 0, n_osop = 0, n_gap = 0, n_esop = 0, n_busy = 0;
  int obs_idx[2];
  bit sel0_h[HMAX];
  bit ov_h[HMAX];
  bit busy_h[HMAX];

  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, exp);
    end
  endtask

  function automatic int brev(input int x);
    int r = 0;
    for (int i = 0; i < LG; i++) if ((x >> i) & 1) r |= 1 << (LG - 1 - i);
    return r;
  endfunction

  // Reference: list of accepted frames (sop cycle, abort cycle), outputs derived per cycle.
  always @(negedge clk) begin : cmp
    int sp, kl, st, e_act, e_sel, e_idx;
    int latest[LG];
    bit e_ov, e_osop, e_busy, e_gap, e_esop, infl, nrun;
    #1;
    if (rst) begin
      chk("reset_outputs", int'({sel, act, oidx, ov, osop, busy, egap, esop}), 0);
      sop_q.delete();
      kill_q.delete();
      m_run = 1'b0;
    end else begin
      e_gap = 0; e_esop = 0; nrun = m_run;
      if (m_run) begin
        if (!vin) begin
          e_gap = 1; kill_q[kill_q.size()-1] = cyc; nrun = 0;
        end else if (sin) begin
          e_esop = 1; kill_q[kill_q.size()-1] = cyc;
        end else if (cyc - m_start == N - 1) begin
          nrun = 0;
        end
      end
      if (vin && sin) begin
        sop_q.push_back(cyc); kill_q.push_back(BIG);
        nrun = 1; m_start = cyc; last_acc = cyc;
      end
      e_ov = 0; e_osop = 0; e_idx = 0; infl = 0; e_act = 0; e_sel = 0;
      for (int s = 0; s < LG; s++) latest[s] = -1;
      foreach (sop_q[i]) begin
        sp = sop_q[i];
        kl = kill_q[i];
        if (cyc >= sp && cyc <= sp + T && cyc <= kl) infl = 1;
        if (kl == BIG && cyc >= sp + T && cyc < sp + T + N) begin
          e_ov = 1;
          e_idx = cyc - sp - T;
          if (cyc == sp + T) e_osop = 1;
        end
        for (int s = 0; s < LG; s++) begin
          st = sp + off[s];
          if (st <= kl && st <= cyc) begin
            if (st > latest[s]) latest[s] = st;
            if (cyc < st + N + (N >> (s + 1))) e_act |= 1 << s;
          end
        end
      end
      for (int s = 0; s < LG; s++)
        if (((e_act >> s) & 1) && ((((cyc - latest[s]) % N) >> (LG - 1 - s)) & 1))
          e_sel |= 1 << s;
`ifdef FFT_SDF_CTRL_BITREV_EN
      e_idx = brev(e_idx);
`endif
      e_busy = m_run | infl | e_ov;
      chk("out_valid", int'(ov), int'(e_ov));
      chk("out_sop", int'(osop), int'(e_osop));
      chk("out_index", int'(oidx), e_idx);
      chk("stage_active", int'(act), e_act);
      chk("stage_sel", int'(sel), e_sel);
      chk("busy", int'(busy), int'(e_busy));
      chk("err_gap", int'(egap), int'(e_gap));
      chk("err_sop", int'(esop), int'(e_esop));
      m_run = nrun;
      if (ov) begin
        if (n_ov < 2) obs_idx[n_ov] = int'(oidx);
        n_ov++;
      end
      if (osop) begin
        n_osop++;
        last_osop = cyc;
      end
      n_gap  += int'(egap);
      n_esop += int'(esop);
      n_busy += int'(busy);
    end
    if (cyc < HMAX) begin
      sel0_h[cyc] = sel[0];
      ov_h[cyc]   = ov;
      busy_h[cyc] = busy;
    end
    cyc++;
  end

  task automatic drive(input bit v, input bit s);
    @(negedge clk);
    vin = v;
    sin = s;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0);
  endtask

  task automatic frame();
    drive(1'b1, 1'b1);
    repeat (N - 1) drive(1'b1, 1'b0);
  endtask

  task automatic clr();
    n_ov = 0; n_osop = 0; n_gap = 0; n_esop = 0; n_busy = 0;
    obs_idx[0] = -1; obs_idx[1] = -1;
  endtask

  initial begin : stim
    int f1, cnt, nfull, kind, m;
    rst = 1'b1; vin = 1'b0; sin = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Single frame
    idle(5); clr(); frame(); idle(40);
    chk("s1_osop_count", n_osop, 1);
    chk("s1_latency", last_osop - last_acc, 19);
    chk("s1_valid_count", n_ov, 16);
    chk("s1_index0", obs_idx[0], 0);
    chk("s1_index1", obs_idx[1], IDX1);
    chk("s1_sel0_before", int'(sel0_h[last_acc + 7]), 0);
    chk("s1_sel0_flip", int'(sel0_h[last_acc + 8]), 1);
    chk("s1_busy_drained", int'(busy_h[cyc - 1]), 0);

    // Three back-to-back frames
    clr(); frame(); f1 = last_acc; frame(); frame(); idle(80);
    chk("s2_osop_count", n_osop, 3);
    chk("s2_valid_count", n_ov, 48);
    chk("s2_last_osop", last_osop - f1, 51);
    cnt = 0;
    for (int c = f1; c < f1 + 67; c++) cnt += int'(busy_h[c]);
    chk("s2_busy_span", cnt, 67);
    cnt = 0;
    for (int c = f1 + 19; c < f1 + 67; c++) cnt += int'(ov_h[c]);
    chk("s2_valid_span", cnt, 48);

    // Gap at in_cnt = 7
    clr(); drive(1'b1, 1'b1); repeat (6) drive(1'b1, 1'b0); idle(60);
    chk("s3_gap_pulses", n_gap, 1);
    chk("s3_no_valid", n_ov, 0);
    chk("s3_no_osop", n_osop, 0);
    chk("s3_busy_drained", int'(busy_h[cyc - 1]), 0);

    // Repeated sop at in_cnt = 5
    clr(); drive(1'b1, 1'b1); repeat (4) drive(1'b1, 1'b0); frame(); idle(50);
    chk("s4_sop_pulses", n_esop, 1);
    chk("s4_gap_pulses", n_gap, 0);
    chk("s4_valid_count", n_ov, 16);
    chk("s4_latency", last_osop - last_acc, 19);

    // Asynchronous reset mid-frame
    clr(); drive(1'b1, 1'b1); repeat (8) drive(1'b1, 1'b0);
    #3;
    rst = 1'b1; vin = 1'b0; sin = 1'b0;
    #1;
    chk("s5_async_active", int'(act), 0);
    chk("s5_async_sel", int'(sel), 0);
    chk("s5_async_busy", int'(busy), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(3); clr(); frame(); idle(40);
    chk("s5_latency", last_osop - last_acc, 19);
    chk("s5_valid_count", n_ov, 16);

    // Stray valid samples while idle
    clr(); repeat (20) drive(1'b1, 1'b0); idle(5);
    chk("s6_gap_pulses", n_gap, 0);
    chk("s6_sop_pulses", n_esop, 0);
    chk("s6_valid_count", n_ov, 0);
    chk("s6_busy_cycles", n_busy, 0);

    // Random frame mix
    clr(); nfull = 0;
    for (int k = 0; k < 24; k++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 5) begin
        frame(); nfull++;
      end else if (kind == 6) begin
        m = $urandom_range(1, 14);
        drive(1'b1, 1'b1); repeat (m) drive(1'b1, 1'b0); drive(1'b0, 1'b0);
      end else if (kind == 7) begin
        m = $urandom_range(1, 14);
        drive(1'b1, 1'b1); repeat (m) drive(1'b1, 1'b0); frame(); nfull++;
      end else if (kind == 8) begin
        idle($urandom_range(1, 6));
      end else begin
        repeat ($urandom_range(1, 5)) drive(1'b1, 1'b0);
      end
    end
    idle(80);
    chk("rnd_frames_out", n_osop, nfull);
    chk("rnd_valid_count", n_ov, 16 * nfull);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_sdf_ctrl.md
Name: fft_sdf_ctrl

Overview:
- Sequencer for a radix-2 single-path delay-feedback (SDF) FFT pipeline. The pipeline is LOG2N cascaded stages; stage s contains a free-running delay line of depth N_POINTS>>(s+1).
- Tracks frame timing from the input stream and drives each stage's butterfly/commutator select.
- Generates the output valid, start-of-packet and index markers after the fixed pipeline latency.
- Sits between the OFDM symbol framer and the FFT datapath; holds no sample data itself.

Parameters:
- N_POINTS, 64, FFT size; power of two, >= 4.
- LOG2N, $clog2(N_POINTS), number of stages; derived, not overridden.
- STAGE_LAT, 1, register cycles per stage after its butterfly (0..3).

Ports:
- clk, input, 1, system clock.
- reset, input, 1, asynchronous active-high reset.
- in_valid, input, 1, input sample present this cycle.
- in_sop, input, 1, first sample of a frame; qualified by in_valid.
- stage_sel, output, LOG2N, bit s = 1: stage s performs butterfly/feeds delay output forward; 0: stage s loads its delay line.
- stage_active, output, LOG2N, bit s = 1 while stage s holds frame data.
- out_valid, output, 1, FFT output sample valid.
- out_sop, output, 1, first output sample of a frame.
- out_index, output, LOG2N, frequency-bin index of the current output.
- busy, output, 1, any frame in flight.
- err_gap, output, 1, one-cycle pulse when in_valid drops mid-frame.
- err_sop, output, 1, one-cycle pulse when in_sop arrives mid-frame.

Behaviour:
- Reset (async assert, synchronous-deassert usage):
  - All outputs 0.
  - All counters 0.
  - FSM in IDLE.
- Latency constants:
  - OFF_s = sum over k<s of ((N_POINTS>>(k+1)) + STAGE_LAT).
  - TOTAL_LAT = N_POINTS - 1 + LOG2N*STAGE_LAT.
- Input FSM, states IDLE, RUN:
  - IDLE -> RUN on in_valid & in_sop. The sample count in_cnt is loaded with 1.
  - In RUN, each in_valid increments in_cnt.
  - At in_cnt == N_POINTS-1 with in_valid, the frame completes. If the next cycle has in_valid & in_sop, stay in RUN with in_cnt = 1 (back-to-back frames, zero bubble). Otherwise go to IDLE.
  - In IDLE, in_valid without in_sop is ignored; no error is raised.
- Error handling:
  - in_valid = 0 in RUN before the frame completes: pulse err_gap, go to IDLE, mark the frame aborted. The aborted frame's token is dropped, so no out_valid is ever produced for it.
  - in_sop in RUN before the frame completes: pulse err_sop, abort the current frame, restart with in_cnt = 1 (the new frame is accepted).
- Phase tracking:
  - A frame token (start marker) enters a TOTAL_LAT+1 deep shift register on each accepted sop.
  - Per stage s, phase_s counts 0..N_POINTS-1 (wrapping) and starts at 0 OFF_s cycles after the input sop.
  - stage_sel[s] = bit (LOG2N-1-s) of phase_s.
  - stage_active[s] is high from phase_s start to N_POINTS + (N_POINTS>>(s+1)) cycles later. It stays continuously high across back-to-back frames.
- Output:
  - out_sop fires exactly TOTAL_LAT cycles after the accepted input sop.
  - out_valid is high for N_POINTS consecutive cycles starting at out_sop.
  - out_index counts 0..N_POINTS-1 in natural order during out_valid, then holds 0.
- busy = (FSM == RUN) | any token in flight | out_valid.
- Simultaneous events:
  - Frame completion and new sop in the same cycle is impossible, since the sop comes on the next sample.
  - An abort on the same cycle as another frame's out_valid does not disturb that earlier frame's output.
- Widths: all counters are LOG2N+1 bits to allow compare at N_POINTS without overflow. Wrap uses modulo N_POINTS.

Optional Feature:
- Macro: FFT_SDF_CTRL_BITREV_EN.
- Defined: out_index presents the bit-reversed count. This is the true bin number for SDF natural-input, bit-reversed-output ordering.
- Undefined: out_index is the natural arrival count. Downstream reorder buffer handles bin mapping.
- Timing of out_valid and out_sop is identical in both builds.

Decomposition:
- Shared package fft_pkg:
  - N_POINTS, LOG2N, STAGE_LAT defaults.
  - Function stage_off(s) returning OFF_s.
  - Function total_lat().
  - Function bitrev(x).
  - typedef enum ctrl_state_t {IDLE, RUN}.
- Sub-module fft_stage_phase: one instance per stage, generate loop.
  - Parameters: STAGE, OFFSET.
  - Takes the token shift-register tap and produces phase_s, stage_sel[s], stage_active[s].

Test Plan (N_POINTS=16, STAGE_LAT=1, TOTAL_LAT=19):
1. Single frame: sop at cycle 10, 16 valid samples -> out_sop at cycle 29; out_valid cycles 29..44; out_index 0..15 (bitrev build: 0,8,4,12,...); stage_sel[0] toggles every 8 cycles from cycle 10.
2. Three back-to-back frames, no bubble -> out_sop at 29, 45, 61; out_valid continuous for 48 cycles; busy high throughout.
3. in_valid drops at in_cnt=7 -> err_gap one-cycle pulse; no out_valid for that frame; busy falls after in-flight drain.
4. in_sop reasserted at in_cnt=5 -> err_sop pulse; new frame's out_sop 19 cycles after that sop; exactly 16 out_valid.
5. reset asserted asynchronously mid-frame (between clock edges) -> all outputs 0 immediately; next sop after deassert behaves as scenario 1.
6. in_valid without in_sop while IDLE for 20 cycles -> no outputs, no errors, busy stays 0.
